// File: rtl/level_sequencer_pkg.sv
// Shared types and default timing constants for the game-flow sequencer.
// Imported by the sequencer and its seconds timer.
package level_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNTDOWN,
        PLAY,
        LEVEL_DONE,
        FINISH,
        TIMEOUT
    } seq_state_t;

    localparam int N_LEVELS_DEF     = 3;
    localparam int FPS_DEF          = 60;
    localparam int COUNTDOWN_S_DEF  = 3;
    localparam int LEVEL_TIME_S_DEF = 99;
    localparam int DONE_FRAMES_DEF  = 120;
    localparam int GOAL_X_DEF       = 700;

    // Seconds counter width, wide enough for the play time.
    localparam int SEC_W = 7;

endpackage

// File: rtl/level_sequencer_sec_timer.sv
// Frame counter producing one-second events plus a loadable
// seconds down-counter shared by countdown and play phases.
module level_sequencer_sec_timer
    import level_sequencer_pkg::*;
#(
    parameter int FRAMES_PER_SEC = FPS_DEF
) (
    input  logic             clk_40,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [SEC_W-1:0] load_val,
    input  logic             frame_tick,
    output logic             sec_ev,
    output logic [SEC_W-1:0] value,
    output logic             zero
);

    localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam logic [FW-1:0] F_LAST = FW'(FRAMES_PER_SEC - 1);

    logic [FW-1:0] fcnt;

    assign sec_ev = frame_tick && (fcnt == F_LAST);
    assign zero   = (value == '0);

    // Frame counter; a clear discards any tick arriving in the same cycle.
    always_ff @(posedge clk_40) begin
        if (rst || clr) begin
            fcnt <= '0;
        end else if (frame_tick) begin
            fcnt <= sec_ev ? '0 : fcnt + FW'(1);
        end
    end

    // Seconds down-counter; load wins, never wraps below zero.
    always_ff @(posedge clk_40) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (sec_ev && !zero) begin
            value <= value - SEC_W'(1);
        end
    end

endmodule

// File: rtl/level_sequencer.sv
// Game-flow scheduler: start screen, countdown, timed play, level
// completion and win/lose screens; gates player motion and level loads.
module level_sequencer
    import level_sequencer_pkg::*;
#(
    parameter int N_LEVELS       = N_LEVELS_DEF,
    parameter int FRAMES_PER_SEC = FPS_DEF,
    parameter int COUNTDOWN_S    = COUNTDOWN_S_DEF,
    parameter int LEVEL_TIME_S   = LEVEL_TIME_S_DEF,
    parameter int DONE_FRAMES    = DONE_FRAMES_DEF,
    parameter int GOAL_X         = GOAL_X_DEF
) (
    input  logic                        clk_40,
    input  logic                        rst,
    input  logic                        frame_tick,
    input  logic                        m_left,
    input  logic                        gpio,
    input  logic [11:0]                 xpos_player1,
    input  logic [11:0]                 xpos_player2,
    output seq_state_t                  seq_state,
    output logic [$clog2(N_LEVELS)-1:0] level,
    output logic [3:0]                  countdown,
    output logic [6:0]                  time_left,
    output logic                        players_en,
    output logic                        level_load
);

    localparam int LW = $clog2(N_LEVELS);
    localparam int DW = $clog2(DONE_FRAMES + 1);
    localparam logic [LW-1:0]    LAST_LEVEL = LW'(N_LEVELS - 1);
    localparam logic [DW-1:0]    DONE_LAST  = DW'(DONE_FRAMES - 1);
    localparam logic [SEC_W-1:0] CD_VAL     = SEC_W'(COUNTDOWN_S);
    localparam logic [SEC_W-1:0] LT_VAL     = SEC_W'(LEVEL_TIME_S);
    localparam logic [11:0]      GOAL       = 12'(GOAL_X);

    seq_state_t       state_n;
    logic [LW-1:0]    level_n;
    logic [3:0]       countdown_n;
    logic [6:0]       time_left_n;
    logic             level_load_n;
    logic [DW-1:0]    done_cnt;
    logic [DW-1:0]    done_n;
    logic             prev_start;
    logic             start_raw;
    logic             start_ev;
    logic             goal;
    logic             t_clr;
    logic             t_load;
    logic [SEC_W-1:0] t_load_val;
    logic             sec_ev;
    logic [SEC_W-1:0] t_value;
    logic             t_zero;

    assign start_raw = m_left | gpio;
    assign start_ev  = start_raw & ~prev_start;
    assign goal      = (xpos_player1 >= GOAL) && (xpos_player2 >= GOAL);

    level_sequencer_sec_timer #(
        .FRAMES_PER_SEC(FRAMES_PER_SEC)
    ) u_timer (
        .clk_40    (clk_40),
        .rst       (rst),
        .clr       (t_clr),
        .load      (t_load),
        .load_val  (t_load_val),
        .frame_tick(frame_tick),
        .sec_ev    (sec_ev),
        .value     (t_value),
        .zero      (t_zero)
    );

    // Next-state and next-output decode for the flow FSM.
    always_comb begin
        state_n      = seq_state;
        level_n      = level;
        countdown_n  = countdown;
        time_left_n  = time_left;
        level_load_n = 1'b0;
        done_n       = done_cnt;
        t_load       = 1'b0;
        t_load_val   = CD_VAL;
        unique case (seq_state)
            IDLE: begin
                if (start_ev) begin
                    state_n      = COUNTDOWN;
                    level_n      = '0;
                    countdown_n  = 4'(COUNTDOWN_S);
                    level_load_n = 1'b1;
                    t_load       = 1'b1;
                end
            end
            COUNTDOWN: begin
                if (sec_ev && !t_zero) begin
                    if (t_value == SEC_W'(1)) begin
                        state_n     = PLAY;
                        countdown_n = '0;
                        time_left_n = 7'(LEVEL_TIME_S);
                        t_load      = 1'b1;
                        t_load_val  = LT_VAL;
                    end else begin
                        countdown_n = 4'(t_value - SEC_W'(1));
                    end
                end
            end
            PLAY: begin
                if (goal) begin
                    state_n = LEVEL_DONE;
                end else if (sec_ev && !t_zero) begin
                    if (t_value == SEC_W'(1)) begin
                        state_n     = TIMEOUT;
                        time_left_n = '0;
                    end else begin
                        time_left_n = 7'(t_value - SEC_W'(1));
                    end
                end
            end
            LEVEL_DONE: begin
                if (frame_tick) begin
                    if (done_cnt == DONE_LAST) begin
                        if (level == LAST_LEVEL) begin
                            state_n = FINISH;
                        end else begin
                            state_n      = COUNTDOWN;
                            level_n      = level + LW'(1);
                            countdown_n  = 4'(COUNTDOWN_S);
                            level_load_n = 1'b1;
                            t_load       = 1'b1;
                        end
                    end else begin
                        done_n = done_cnt + DW'(1);
                    end
                end
            end
            FINISH, TIMEOUT: begin
                if (start_ev) begin
                    state_n     = IDLE;
                    level_n     = '0;
                    time_left_n = '0;
                end
            end
            default: begin
                state_n     = IDLE;
                level_n     = '0;
                countdown_n = '0;
                time_left_n = '0;
            end
        endcase
        t_clr = (state_n != seq_state);
        if (t_clr) begin
            done_n = '0;
        end
    end

    // Registered state, outputs, done-frame count and start edge detect.
    always_ff @(posedge clk_40) begin
        if (rst) begin
            seq_state  <= IDLE;
            level      <= '0;
            countdown  <= '0;
            time_left  <= '0;
            players_en <= 1'b0;
            level_load <= 1'b0;
            done_cnt   <= '0;
            prev_start <= 1'b0;
        end else begin
            seq_state  <= state_n;
            level      <= level_n;
            countdown  <= countdown_n;
            time_left  <= time_left_n;
            players_en <= (state_n == PLAY);
            level_load <= level_load_n;
            done_cnt   <= done_n;
            prev_start <= start_raw;
        end
    end

endmodule

// File: tb/tb_level_sequencer.sv
// Self-checking bench: two sequencers with different play times share
// stimulus and are compared to a seconds/ticks arithmetic model.
`timescale 1ns/1ps
module tb_level_sequencer;
    import level_sequencer_pkg::*;

    localparam int FPS  = 4;
    localparam int CD   = 3;
    localparam int DONE = 8;
    localparam int NL   = 3;
    localparam int LT0  = 99;
    localparam int LT1  = 2;

    logic        clk_40 = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        m_left = 1'b0;
    logic        gpio = 1'b0;
    logic [11:0] x1 = '0;
    logic [11:0] x2 = '0;

    seq_state_t  st [2];
    logic [1:0]  lvl [2];
    logic [3:0]  cd_o [2];
    logic [6:0]  tl_o [2];
    logic        pen [2];
    logic        ld [2];

    seq_state_t  ms [2];
    int          mlevel [2];
    int          mticks [2];
    int          mcd [2];
    int          mtl [2];
    bit          mload [2];
    bit          mpen [2];
    bit          mprev;

    int n_checks = 0;
    int n_fail = 0;

    level_sequencer #(
        .N_LEVELS(NL), .FRAMES_PER_SEC(FPS), .COUNTDOWN_S(CD),
        .LEVEL_TIME_S(LT0), .DONE_FRAMES(DONE), .GOAL_X(700)
    ) u_a (
        .clk_40(clk_40), .rst(rst), .frame_tick(frame_tick),
        .m_left(m_left), .gpio(gpio),
        .xpos_player1(x1), .xpos_player2(x2),
        .seq_state(st[0]), .level(lvl[0]), .countdown(cd_o[0]),
        .time_left(tl_o[0]), .players_en(pen[0]), .level_load(ld[0])
    );

    level_sequencer #(
        .N_LEVELS(NL), .FRAMES_PER_SEC(FPS), .COUNTDOWN_S(CD),
        .LEVEL_TIME_S(LT1), .DONE_FRAMES(DONE), .GOAL_X(700)
    ) u_b (
        .clk_40(clk_40), .rst(rst), .frame_tick(frame_tick),
        .m_left(m_left), .gpio(gpio),
        .xpos_player1(x1), .xpos_player2(x2),
        .seq_state(st[1]), .level(lvl[1]), .countdown(cd_o[1]),
        .time_left(tl_o[1]), .players_en(pen[1]), .level_load(ld[1])
    );

    // 40 MHz-ish clock.
    always #12 clk_40 = ~clk_40;

    task automatic model_update();
        bit raw, ev, goal;
        seq_state_t nx;
        int lt;
        raw  = m_left | gpio;
        ev   = raw && !mprev;
        goal = (x1 >= 12'd700) && (x2 >= 12'd700);
        for (int i = 0; i < 2; i++) begin
            lt = (i == 0) ? LT0 : LT1;
            if (rst) begin
                ms[i] = IDLE; mlevel[i] = 0; mcd[i] = 0; mtl[i] = 0;
                mload[i] = 0; mpen[i] = 0; mticks[i] = 0;
            end else begin
                mload[i] = 0;
                nx = ms[i];
                case (ms[i])
                    IDLE: if (ev) begin
                        nx = COUNTDOWN; mlevel[i] = 0;
                        mcd[i] = CD; mload[i] = 1;
                    end
                    COUNTDOWN: if (frame_tick) begin
                        mticks[i]++;
                        mcd[i] = CD - mticks[i] / FPS;
                        if (mticks[i] == CD * FPS) begin
                            nx = PLAY; mtl[i] = lt;
                        end
                    end
                    PLAY: if (goal) begin
                        nx = LEVEL_DONE;
                    end else if (frame_tick) begin
                        mticks[i]++;
                        mtl[i] = lt - mticks[i] / FPS;
                        if (mticks[i] == lt * FPS) nx = TIMEOUT;
                    end
                    LEVEL_DONE: if (frame_tick) begin
                        mticks[i]++;
                        if (mticks[i] == DONE) begin
                            if (mlevel[i] == NL - 1) begin
                                nx = FINISH;
                            end else begin
                                nx = COUNTDOWN; mlevel[i]++;
                                mcd[i] = CD; mload[i] = 1;
                            end
                        end
                    end
                    default: if (ev) begin
                        nx = IDLE; mlevel[i] = 0; mtl[i] = 0;
                    end
                endcase
                if (nx != ms[i]) mticks[i] = 0;
                ms[i] = nx;
                mpen[i] = (nx == PLAY);
            end
        end
        mprev = rst ? 1'b0 : raw;
    endtask

    task automatic step();
        @(posedge clk_40);
        model_update();
        #1;
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    task automatic start_pulse();
        gpio = 1'b1;
        step();
        gpio = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({st[i], lvl[i], cd_o[i], tl_o[i], pen[i], ld[i]} !== 18'd0) begin
                n_fail++;
                $display("FAIL reset dut%0d got st=%0d lvl=%0d cd=%0d tl=%0d en=%0d ld=%0d want all 0",
                         i, st[i], lvl[i], cd_o[i], tl_o[i], pen[i], ld[i]);
            end
        end
    endtask

    task automatic test_start_hold();
        int loads, trans;
        seq_state_t prev;
        loads = 0;
        trans = 0;
        prev = st[0];
        m_left = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (ld[0]) loads++;
            if (st[0] != prev) trans++;
            prev = st[0];
            if (k == 0) begin
                n_checks++;
                if (st[0] !== COUNTDOWN || lvl[0] !== 2'd0 || cd_o[0] !== 4'd3 || ld[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL start_first got st=%0d lvl=%0d cd=%0d ld=%0d want st=%0d lvl=0 cd=3 ld=1",
                             st[0], lvl[0], cd_o[0], ld[0], COUNTDOWN);
                end
            end
        end
        m_left = 1'b0;
        step();
        n_checks++;
        if (loads != 1 || trans != 1) begin
            n_fail++;
            $display("FAIL start_hold got loads=%0d trans=%0d want 1 1", loads, trans);
        end
    endtask

    task automatic test_countdown();
        tick(11);
        n_checks++;
        if (st[0] !== COUNTDOWN || cd_o[0] !== 4'd1) begin
            n_fail++;
            $display("FAIL cd_11 got st=%0d cd=%0d want st=%0d cd=1", st[0], cd_o[0], COUNTDOWN);
        end
        tick(1);
        n_checks++;
        if (st[0] !== PLAY || tl_o[0] !== 7'd99 || pen[0] !== 1'b1 || cd_o[0] !== 4'd0) begin
            n_fail++;
            $display("FAIL cd_12 got st=%0d tl=%0d en=%0d cd=%0d want st=%0d tl=99 en=1 cd=0",
                     st[0], tl_o[0], pen[0], cd_o[0], PLAY);
        end
        n_checks++;
        if (st[1] !== PLAY || tl_o[1] !== 7'd2) begin
            n_fail++;
            $display("FAIL cd_12_b got st=%0d tl=%0d want st=%0d tl=2", st[1], tl_o[1], PLAY);
        end
    endtask

    task automatic test_goal();
        logic [11:0] xa [3];
        logic [11:0] xb [3];
        xa = '{12'd700, 12'd699, 12'd4095};
        xb = '{12'd699, 12'd700, 12'd0};
        for (int k = 0; k < 3; k++) begin
            x1 = xa[k];
            x2 = xb[k];
            step();
            n_checks++;
            if (st[0] !== PLAY || pen[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL no_goal_%0d got st=%0d en=%0d want st=%0d en=1", k, st[0], pen[0], PLAY);
            end
        end
        x1 = 12'd700;
        x2 = 12'd700;
        step();
        x1 = '0;
        x2 = '0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (st[i] !== LEVEL_DONE || pen[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL goal dut%0d got st=%0d en=%0d want st=%0d en=0", i, st[i], pen[i], LEVEL_DONE);
            end
        end
    endtask

    task automatic test_timeout();
        rst = 1'b1;
        step();
        rst = 1'b0;
        start_pulse();
        tick(12);
        tick(8);
        n_checks++;
        if (st[1] !== TIMEOUT || tl_o[1] !== 7'd0 || pen[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout got st=%0d tl=%0d en=%0d want st=%0d tl=0 en=0", st[1], tl_o[1], pen[1], TIMEOUT);
        end
        n_checks++;
        if (st[0] !== PLAY || tl_o[0] !== 7'd97) begin
            n_fail++;
            $display("FAIL play_97 got st=%0d tl=%0d want st=%0d tl=97", st[0], tl_o[0], PLAY);
        end
        tick(2);
        n_checks++;
        if (st[1] !== TIMEOUT || tl_o[1] !== 7'd0) begin
            n_fail++;
            $display("FAIL timeout_hold got st=%0d tl=%0d want st=%0d tl=0", st[1], tl_o[1], TIMEOUT);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        start_pulse();
        tick(12);
        tick(7);
        x1 = 12'd800;
        x2 = 12'd700;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        x1 = '0;
        x2 = '0;
        n_checks++;
        if (st[1] !== LEVEL_DONE || tl_o[1] !== 7'd1) begin
            n_fail++;
            $display("FAIL goal_vs_sec got st=%0d tl=%0d want st=%0d tl=1", st[1], tl_o[1], LEVEL_DONE);
        end
        n_checks++;
        if (st[0] !== LEVEL_DONE || tl_o[0] !== 7'd98) begin
            n_fail++;
            $display("FAIL goal_freeze got st=%0d tl=%0d want st=%0d tl=98", st[0], tl_o[0], LEVEL_DONE);
        end
    endtask

    task automatic test_levels();
        int loads;
        loads = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        start_pulse();
        if (ld[0]) loads++;
        for (int l = 0; l < NL; l++) begin
            tick(12);
            n_checks++;
            if (st[0] !== PLAY || lvl[0] !== 2'(l)) begin
                n_fail++;
                $display("FAIL level_%0d got st=%0d lvl=%0d want st=%0d lvl=%0d", l, st[0], lvl[0], PLAY, l);
            end
            x1 = 12'd900;
            x2 = 12'd701;
            step();
            x1 = '0;
            x2 = '0;
            for (int k = 0; k < DONE; k++) begin
                frame_tick = 1'b1;
                step();
                if (ld[0]) loads++;
                frame_tick = 1'b0;
                step();
                if (ld[0]) loads++;
            end
        end
        n_checks++;
        if (st[0] !== FINISH || lvl[0] !== 2'd2 || loads != 3) begin
            n_fail++;
            $display("FAIL finish got st=%0d lvl=%0d loads=%0d want st=%0d lvl=2 loads=3",
                     st[0], lvl[0], loads, FINISH);
        end
        tick(3);
        n_checks++;
        if (st[1] !== FINISH || lvl[1] !== 2'd2 || ld[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL finish_hold got st=%0d lvl=%0d ld=%0d want st=%0d lvl=2 ld=0",
                     st[1], lvl[1], ld[1], FINISH);
        end
        start_pulse();
        n_checks++;
        if (st[0] !== IDLE || lvl[0] !== 2'd0 || tl_o[0] !== 7'd0) begin
            n_fail++;
            $display("FAIL restart got st=%0d lvl=%0d tl=%0d want st=%0d lvl=0 tl=0",
                     st[0], lvl[0], tl_o[0], IDLE);
        end
    endtask

    task automatic test_reset_midplay();
        rst = 1'b1;
        step();
        rst = 1'b0;
        start_pulse();
        tick(12);
        tick(49 * FPS);
        n_checks++;
        if (st[0] !== PLAY || tl_o[0] !== 7'd50) begin
            n_fail++;
            $display("FAIL tl_50 got st=%0d tl=%0d want st=%0d tl=50", st[0], tl_o[0], PLAY);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({st[i], lvl[i], cd_o[i], tl_o[i], pen[i], ld[i]} !== 18'd0) begin
                n_fail++;
                $display("FAIL abort dut%0d got st=%0d lvl=%0d cd=%0d tl=%0d en=%0d ld=%0d want all 0",
                         i, st[i], lvl[i], cd_o[i], tl_o[i], pen[i], ld[i]);
            end
        end
        step();
        n_checks++;
        if (st[0] !== IDLE || ld[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_after got st=%0d ld=%0d want st=%0d ld=0", st[0], ld[0], IDLE);
        end
    endtask

    task automatic test_random();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            frame_tick = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) m_left = ~m_left;
            if ($urandom_range(0, 24) == 0) gpio = ~gpio;
            if ($urandom_range(0, 15) == 0) begin
                x1 = 12'($urandom_range(680, 720));
                x2 = 12'($urandom_range(680, 720));
            end else if ($urandom_range(0, 15) == 0) begin
                x1 = '0;
                x2 = '0;
            end
            step();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if ({st[i], lvl[i], cd_o[i], tl_o[i], pen[i], ld[i]} !==
                    {ms[i], 2'(mlevel[i]), 4'(mcd[i]), 7'(mtl[i]), mpen[i], mload[i]}) begin
                    n_fail++;
                    $display("FAIL rand c%0d dut%0d got st=%0d lvl=%0d cd=%0d tl=%0d en=%0d ld=%0d want st=%0d lvl=%0d cd=%0d tl=%0d en=%0d ld=%0d",
                             c, i, st[i], lvl[i], cd_o[i], tl_o[i], pen[i], ld[i],
                             ms[i], mlevel[i], mcd[i], mtl[i], mpen[i], mload[i]);
                end
            end
        end
        rst = 1'b0;
        m_left = 1'b0;
        gpio = 1'b0;
        frame_tick = 1'b0;
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_start_hold();
        test_countdown();
        test_goal();
        test_timeout();
        test_levels();
        test_reset_midplay();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
